a2d_chnl_sched: RTL and testbench

//  Sequences A2D conversions over the shared SPI master for the four analog channels:

---
 rtl/a2d_chnl_sched_if.sv | 27 ++
 rtl/a2d_chnl_sched.sv | 203 ++++++++++++++++++++
 tb/tb_a2d_chnl_sched.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/a2d_chnl_sched_if.sv
// a2d_chnl_sched_if
//   Handshake between the channel scheduler and the shared SPI master.
//   wrt      1   scheduler -> SPI: start one transaction (1-cycle pulse)
//   cmd      16  scheduler -> SPI: command word, stable from wrt until done
//   done     1   SPI -> scheduler: transaction complete (1-cycle pulse)
//   rd_data  16  SPI -> scheduler: read data, valid while done is high
//   modport master: the scheduler side; modport slave: the SPI master side.
interface a2d_chnl_sched_if;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;

  modport master (
    output wrt,
    output cmd,
    input  done,
    input  rd_data
  );

  modport slave (
    input  wrt,
    input  cmd,
    output done,
    output rd_data
  );
endinterface

// File: rtl/a2d_chnl_sched.sv
// a2d_chnl_sched
//   Runs one round of A2D conversions (lft, rght, steer, batt) over the shared SPI master for
//   every nxt request, holding the latest results. Each channel takes a command transaction, one
//   idle gap cycle, and a read transaction. A watchdog aborts a round whose SPI master hangs.
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   nxt        in   1-cycle request to start a round (one extra request is remembered)
//   spi        if   master side of a2d_chnl_sched_if (wrt/cmd out, done/rd_data in)
//   lft_ld     out  12-bit left load cell result
//   rght_ld    out  12-bit right load cell result
//   steer_pot  out  12-bit steering pot result
//   batt       out  12-bit battery result
//   rnd_vld    out  1-cycle pulse: round finished, all four results updated
//   err        out  1-cycle pulse: watchdog expired, round aborted
// Configuration
//   FILT_EN    when defined, lft_ld/rght_ld are IIR filtered: new = (3*old + sample) >> 2,
//              with the first write after reset loading the sample directly.
module a2d_chnl_sched #(
  parameter logic [2:0]  CH_LFT   = 3'd0,
  parameter logic [2:0]  CH_RGHT  = 3'd4,
  parameter logic [2:0]  CH_STEER = 3'd5,
  parameter logic [2:0]  CH_BATT  = 3'd6,
  parameter int unsigned TMO_CYC  = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               nxt,
  a2d_chnl_sched_if.master   spi,
  output logic [11:0]        lft_ld,
  output logic [11:0]        rght_ld,
  output logic [11:0]        steer_pot,
  output logic [11:0]        batt,
  output logic               rnd_vld,
  output logic               err
);

  localparam int unsigned WdW   = $clog2(TMO_CYC);
  localparam logic [WdW-1:0] WdMax = WdW'(TMO_CYC - 1);

  typedef enum logic [2:0] {StIdle, StCmd, StWcmd, StGap, StRd, StWrd} state_t;

  state_t         state_q, state_d;
  logic           pend_q, pend_d;
  logic [1:0]     idx_q, idx_d;
  logic [WdW-1:0] wdog_q, wdog_d;
  logic           rnd_vld_q, rnd_vld_d;
  logic           err_q, err_d;
  logic           wrt;
  logic           ld_en;
  logic [2:0]     ch_sel;
  logic [11:0]    sample;
  logic [11:0]    lft_q, rght_q, steer_q, batt_q;
  logic [11:0]    lft_nxt, rght_nxt;

  assign sample = spi.rd_data[11:0];

  // cmd follows idx, which only changes between channels, so it is stable from wrt until done.
  always_comb begin
    ch_sel = CH_LFT;
    unique case (idx_q)
      2'd0: ch_sel = CH_LFT;
      2'd1: ch_sel = CH_RGHT;
      2'd2: ch_sel = CH_STEER;
      2'd3: ch_sel = CH_BATT;
    endcase
  end

  assign spi.cmd = {2'b00, ch_sel, 11'h000};
  assign spi.wrt = wrt;

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    idx_d     = idx_q;
    wdog_d    = '0;
    wrt       = 1'b0;
    ld_en     = 1'b0;
    rnd_vld_d = 1'b0;
    err_d     = 1'b0;
    // Requests arriving mid-round collapse into a single pending round.
    if (nxt && (state_q != StIdle)) pend_d = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (nxt || pend_q) begin
          pend_d  = 1'b0;
          idx_d   = 2'd0;
          state_d = StCmd;
        end
      end
      StCmd: begin
        wrt     = 1'b1;
        state_d = StWcmd;
      end
      StWcmd: begin
        if (spi.done) begin
          state_d = StGap;
        end else if (wdog_q == WdMax) begin
          err_d   = 1'b1;
          pend_d  = 1'b0;
          state_d = StIdle;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      StGap: begin
        state_d = StRd;
      end
      StRd: begin
        wrt     = 1'b1;
        state_d = StWrd;
      end
      StWrd: begin
        if (spi.done) begin
          ld_en = 1'b1;
          if (idx_q == 2'd3) begin
            rnd_vld_d = 1'b1;
            state_d   = StIdle;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StCmd;
          end
        end else if (wdog_q == WdMax) begin
          err_d   = 1'b1;
          pend_d  = 1'b0;
          state_d = StIdle;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pend_q    <= 1'b0;
      idx_q     <= 2'd0;
      wdog_q    <= '0;
      rnd_vld_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      idx_q     <= idx_d;
      wdog_q    <= wdog_d;
      rnd_vld_q <= rnd_vld_d;
      err_q     <= err_d;
    end
  end

`ifdef FILT_EN
  logic        lft_seen_q, rght_seen_q;
  logic [13:0] lft_sum, rght_sum;

  always_comb begin
    lft_sum  = 14'd3 * {2'b00, lft_q} + {2'b00, sample};
    rght_sum = 14'd3 * {2'b00, rght_q} + {2'b00, sample};
    lft_nxt  = lft_seen_q ? lft_sum[13:2] : sample;
    rght_nxt = rght_seen_q ? rght_sum[13:2] : sample;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_seen_q  <= 1'b0;
      rght_seen_q <= 1'b0;
    end else if (ld_en) begin
      if (idx_q == 2'd0) lft_seen_q <= 1'b1;
      if (idx_q == 2'd1) rght_seen_q <= 1'b1;
    end
  end
`else
  always_comb begin
    lft_nxt  = sample;
    rght_nxt = sample;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_q   <= 12'h000;
      rght_q  <= 12'h000;
      steer_q <= 12'h000;
      batt_q  <= 12'h000;
    end else if (ld_en) begin
      unique case (idx_q)
        2'd0: lft_q   <= lft_nxt;
        2'd1: rght_q  <= rght_nxt;
        2'd2: steer_q <= sample;
        2'd3: batt_q  <= sample;
      endcase
    end
  end

  assign lft_ld    = lft_q;
  assign rght_ld   = rght_q;
  assign steer_pot = steer_q;
  assign batt      = batt_q;
  assign rnd_vld   = rnd_vld_q;
  assign err       = err_q;

endmodule

// File: tb/tb_a2d_chnl_sched.sv
// tb_a2d_chnl_sched
//   Bench for a2d_chnl_sched. An SPI responder answers every wrt after a random delay, checks the
//   command sequence and gap timing, and updates a per-channel result model on each read; finished
//   rounds are queued and a monitor compares them on rnd_vld. Honours FILT_EN like the design.
module tb_a2d_chnl_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        nxt = 1'b0;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;
  logic        rnd_vld, err;

  a2d_chnl_sched_if spi ();

  a2d_chnl_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .nxt       (nxt),
    .spi       (spi),
    .lft_ld    (lft_ld),
    .rght_ld   (rght_ld),
    .steer_pot (steer_pot),
    .batt      (batt),
    .rnd_vld   (rnd_vld),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: result per channel in round order, plus filter "seen" flags.
  typedef struct {
    logic [11:0] l;
    logic [11:0] r;
    logic [11:0] s;
    logic [11:0] b;
  } res_t;

  logic [11:0] m_res [4];
  bit          m_seen [4];
  logic [2:0]  chs [4];
  res_t        exp_q [$];
  logic [11:0] sample_q [$];

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_res[i]  = 12'h000;
      m_seen[i] = 1'b0;
    end
    exp_q.delete();
    sample_q.delete();
  endtask

  task automatic model_update(input int ch, input logic [11:0] s);
`ifdef FILT_EN
    if (ch < 2 && m_seen[ch]) m_res[ch] = 12'((3 * int'(m_res[ch]) + int'(s)) / 4);
    else m_res[ch] = s;
`else
    m_res[ch] = s;
`endif
    m_seen[ch] = 1'b1;
  endtask

  // Responder state, shared with the stimulus process for synchronisation only.
  int  txn = 0;
  int  cur = 0;
  int  cnt = 0;
  bit  busy = 1'b0;
  bit  supp = 1'b0;
  int  done_cyc = 0;
  int  supp_cyc = 0;
  logic [15:0] held = 16'h0;
  logic [11:0] smp;

  // Monitor state.
  int rnd_cnt = 0;
  int err_cnt = 0;
  int rnd_cyc = -10;
  int err_cyc = 0;
  int b2b     = 0;

  initial begin
    chs[0] = 3'd0;
    chs[1] = 3'd4;
    chs[2] = 3'd5;
    chs[3] = 3'd6;
    spi.done    = 1'b0;
    spi.rd_data = 16'h0;
    forever begin
      @(posedge clk);
      #1;
      spi.done = 1'b0;
      if (!rst_n || err) begin
        busy = 1'b0;
        txn  = 0;
        supp = 1'b0;
        if (!rst_n) model_reset();
      end else if (spi.wrt) begin
        check("wrt_without_done", 32'(busy), 32'd0);
        check("cmd", 32'(spi.cmd), 32'({2'b00, chs[txn/2], 11'h000}));
        if (txn % 2 == 1) check("gap_cycles", 32'(cyc - done_cyc), 32'd2);
        if (txn == 0 && rnd_cyc == cyc - 1) b2b++;
        busy = 1'b1;
        cur  = txn;
        held = spi.cmd;
        cnt  = $urandom_range(1, 4);
        txn  = (txn + 1) % 8;
        if (supp && cur == 5) supp_cyc = cyc;
      end else if (busy) begin
        cnt--;
        if (cnt <= 0 && !(supp && cur == 5)) begin
          check("cmd_hold", 32'(spi.cmd), 32'(held));
          if (cur % 2 == 1 && sample_q.size() > 0) smp = sample_q.pop_front();
          else smp = 12'($urandom);
          spi.rd_data = {4'($urandom), smp};
          spi.done    = 1'b1;
          busy        = 1'b0;
          done_cyc    = cyc;
          if (cur % 2 == 1) model_update(cur / 2, smp);
          if (cur == 7) begin
            res_t e;
            e.l = m_res[0];
            e.r = m_res[1];
            e.s = m_res[2];
            e.b = m_res[3];
            exp_q.push_back(e);
          end
        end
      end
    end
  end

  initial begin
    res_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rnd_vld && rst_n) begin
        rnd_cnt++;
        rnd_cyc = cyc;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rnd_vld: got a pulse, expected none (no round queued)");
        end else begin
          e = exp_q.pop_front();
          check("rnd_lft", 32'(lft_ld), 32'(e.l));
          check("rnd_rght", 32'(rght_ld), 32'(e.r));
          check("rnd_steer", 32'(steer_pot), 32'(e.s));
          check("rnd_batt", 32'(batt), 32'(e.b));
        end
      end
      if (err && rst_n) begin
        err_cnt++;
        err_cyc = cyc;
      end
    end
  end

  task automatic pulse_nxt();
    @(negedge clk);
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
  endtask

  task automatic wait_rnd(input int target, input int budget, input string name);
    int n = 0;
    while (rnd_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (rnd_cnt < target) begin
      total++;
      bad++;
      $display("FAIL %s: got %0d rounds, expected %0d within %0d cycles", name, rnd_cnt,
               target, budget);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wrt"}, 32'(spi.wrt), 32'd0);
    check({tag, "_cmd"}, 32'(spi.cmd), 32'd0);
    check({tag, "_lft"}, 32'(lft_ld), 32'd0);
    check({tag, "_rght"}, 32'(rght_ld), 32'd0);
    check({tag, "_steer"}, 32'(steer_pot), 32'd0);
    check({tag, "_batt"}, 32'(batt), 32'd0);
    check({tag, "_rnd_vld"}, 32'(rnd_vld), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    int r0, b0, e0, n;
    logic [11:0] s_keep, b_keep;

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed round with known read data.
    sample_q.push_back(12'hA5A);
    sample_q.push_back(12'h123);
    sample_q.push_back(12'h7FF);
    sample_q.push_back(12'h800);
    pulse_nxt();
    wait_rnd(1, 500, "t1_round");
    check("t1_lft", 32'(lft_ld), 32'h A5A);
    check("t1_rght", 32'(rght_ld), 32'h123);
    check("t1_steer", 32'(steer_pot), 32'h7FF);
    check("t1_batt", 32'(batt), 32'h800);
    repeat (50) @(negedge clk);
    check("t1_rnd_count", 32'(rnd_cnt), 32'd1);

    // Three requests mid-round yield exactly one extra, back-to-back round.
    r0 = rnd_cnt;
    b0 = b2b;
    pulse_nxt();
    n = 0;
    while (txn < 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (3) pulse_nxt();
    wait_rnd(r0 + 2, 1000, "t2_rounds");
    repeat (150) @(negedge clk);
    check("t2_rnd_count", 32'(rnd_cnt), 32'(r0 + 2));
    check("t2_back_to_back", 32'(b2b), 32'(b0 + 1));

    // Request on the cycle of the final done queues a round that follows immediately.
    r0 = rnd_cnt;
    b0 = b2b;
    pulse_nxt();
    n = 0;
    forever begin
      @(posedge clk);
      #2;
      n++;
      if ((spi.done && cur == 7) || n > 500) break;
    end
    nxt = 1'b1;
    @(posedge clk);
    #2;
    nxt = 1'b0;
    wait_rnd(r0 + 2, 1000, "t2b_rounds");
    repeat (150) @(negedge clk);
    check("t2b_rnd_count", 32'(rnd_cnt), 32'(r0 + 2));
    check("t2b_back_to_back", 32'(b2b), 32'(b0 + 1));

    // Watchdog: the steer read never completes.
    r0 = rnd_cnt;
    e0 = err_cnt;
    s_keep = m_res[2];
    b_keep = m_res[3];
    sample_q.push_back(12'h111);
    sample_q.push_back(12'h222);
    supp = 1'b1;
    pulse_nxt();
    n = 0;
    while (err_cnt == e0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("t3_err_count", 32'(err_cnt), 32'(e0 + 1));
    check("t3_err_delay", 32'(err_cyc - supp_cyc), 32'd1025);
    repeat (20) @(negedge clk);
    check("t3_no_rnd_vld", 32'(rnd_cnt), 32'(r0));
    check("t3_lft", 32'(lft_ld), 32'(m_res[0]));
    check("t3_rght", 32'(rght_ld), 32'(m_res[1]));
    check("t3_steer_kept", 32'(steer_pot), 32'(s_keep));
    check("t3_batt_kept", 32'(batt), 32'(b_keep));
    pulse_nxt();
    wait_rnd(r0 + 1, 500, "t3_recover_round");

    // Asynchronous reset in the middle of a read.
    pulse_nxt();
    n = 0;
    while (!(busy && cur % 2 == 1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    r0 = rnd_cnt;
    sample_q.push_back(12'h400);
    repeat (3) sample_q.push_back(12'($urandom));
    sample_q.push_back(12'h800);
    repeat (3) sample_q.push_back(12'($urandom));
    pulse_nxt();
    wait_rnd(r0 + 1, 500, "t4_round1");
    check("t4_lft_first", 32'(lft_ld), 32'h400);
    pulse_nxt();
    wait_rnd(r0 + 2, 500, "t4_round2");
`ifdef FILT_EN
    check("t4_lft_second", 32'(lft_ld), 32'h500);
`else
    check("t4_lft_second", 32'(lft_ld), 32'h800);
`endif

    // Random rounds with random read data.
    for (int i = 0; i < 6; i++) begin
      r0 = rnd_cnt;
      pulse_nxt();
      wait_rnd(r0 + 1, 500, "rand_round");
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
